// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Program-counter stage in front of the instruction-memory fetch block.
// It boots, steps sequentially, takes ARM-style PC-relative branches and
// honours stalls. It halts for good, until the next reset, when the next PC
// would fall outside [RESET_PC, RESET_PC + 4*MEM_WORDS).
//
// Optional build macro: BRANCH_BUBBLE_EN
//   When defined, every taken in-range branch is followed by one FLUSH
//   cycle with fetch_enable low. A stall during FLUSH lengthens it.
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   reset         asynchronous, active-high reset
//   stall         hold pc and state for this cycle
//   branch_taken  redirect to the branch target this cycle
//   branch_offset signed word offset, taken from the imm24 field
//   pc            current PC (drives the fetch block's read_address)
//   fetch_enable  drives the fetch block's enable
//   pc_plus4      pc + 4 (link value for BL)
//   halt          sticky; execution has left the populated memory
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [23:0] branch_offset,
  output logic [31:0] pc,
  output logic        fetch_enable,
  output logic [31:0] pc_plus4,
  output logic        halt
);

  // END_ADDR is held in 33 bits so that a window ending exactly at 2^32
  // still compares correctly.
  localparam logic [32:0] END_ADDR = {1'b0, RESET_PC} + 33'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
`ifdef BRANCH_BUBBLE_EN
    ,FLUSH = 2'd3
`endif
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_n;
  logic [31:0] offset_bytes;
  logic [31:0] target;
  logic        in_range;

  // Word offset, sign-extended and shifted into a byte offset.
  assign offset_bytes = {{6{branch_offset[23]}}, branch_offset, 2'b00};
  assign target       = branch_taken ? (pc + 32'd8 + offset_bytes) : (pc + 32'd4);
  // The target wraps modulo 2^32, so a wrap below RESET_PC fails the lower bound.
  assign in_range     = (target >= RESET_PC) && ({1'b0, target} < END_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (!stall) begin
          if (in_range) begin
            pc_n = target;
`ifdef BRANCH_BUBBLE_EN
            if (branch_taken) state_n = FLUSH;
`endif
          end else begin
            state_n = HALT;
          end
        end
      end
      HALT: state_n = HALT;
`ifdef BRANCH_BUBBLE_EN
      FLUSH: if (!stall) state_n = RUN;
`endif
      default: state_n = state;
    endcase
  end

  assign fetch_enable = (state == RUN);
  assign halt         = (state == HALT);
  assign pc_plus4     = pc + 32'd4;

endmodule
